// File: rtl/od_echo_responder.sv
// Ultrasonic ranging sensor stand-in: accepts a trigger pulse, waits out the
// transducer burst delay, then drives an echo pulse whose width encodes the
// programmed distance, followed by a dead time during which triggers are ignored.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a trigger rising edge
// ST_TRIG    | trigger high, measuring its width (saturating count)
// ST_BURST   | accepted trigger fell, emulating burst delay
// ST_ECHO    | echo high for the latched width
// ST_HOLDOFF | dead time after echo fall, triggers ignored
module od_echo_responder #(
  parameter int TRIG_MIN_CYCLES = 500,
  parameter int BURST_CYCLES    = 10000,
  parameter int TIMEOUT_CYCLES  = 1900000,
  parameter int HOLDOFF_CYCLES  = 500000,
  parameter int W               = 22
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         trigger,
  input  logic [W-1:0] echo_width_cycles,
  input  logic         object_present,
  output logic         echo,
  output logic         busy,
  output logic         done,
  output logic         trig_reject
);

  // Down-counters load "N-1" and terminate on zero, so N cycles elapse.
  localparam logic [W-1:0] ONE_W       = W'(1);
  localparam logic [W-1:0] TRIG_MIN_W  = W'(TRIG_MIN_CYCLES);
  localparam logic [W-1:0] TIMEOUT_W   = W'(TIMEOUT_CYCLES);
  localparam logic [W-1:0] BURST_TC_W  = W'(BURST_CYCLES - 1);
  localparam logic [W-1:0] HOLDOFF_TC_W = W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_BURST,
    ST_ECHO,
    ST_HOLDOFF
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   width_q, width_d;
  logic           echo_q, echo_d;
  logic           done_q, done_d;
  logic           rej_q, rej_d;
  logic           trig_q;
  logic           rise;
  logic [W-1:0]   width_sel;

  assign rise        = trigger & ~trig_q;
  assign busy        = (state_q != ST_IDLE);
  assign echo        = echo_q;
  assign done        = done_q;
  assign trig_reject = rej_q;

  // Width to latch at trigger fall: no object or over-range forces timeout,
  // zero is promoted to one so an echo is always produced.
  always_comb begin
    width_sel = echo_width_cycles;
    if (!object_present || (echo_width_cycles > TIMEOUT_W)) begin
      width_sel = TIMEOUT_W;
    end else if (echo_width_cycles == '0) begin
      width_sel = ONE_W;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    echo_d  = echo_q;
    done_d  = 1'b0;
    rej_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_TRIG;
          cnt_d   = ONE_W;
        end
      end
      ST_TRIG: begin
        if (trigger) begin
          if (cnt_q < TRIG_MIN_W) cnt_d = cnt_q + ONE_W;
        end else if (cnt_q >= TRIG_MIN_W) begin
          state_d = ST_BURST;
          cnt_d   = BURST_TC_W;
          width_d = width_sel;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          rej_d   = 1'b1;
        end
      end
      ST_BURST: begin
        if (cnt_q == '0) begin
          state_d = ST_ECHO;
          echo_d  = 1'b1;
          cnt_d   = width_q - ONE_W;
        end else begin
          cnt_d = cnt_q - ONE_W;
        end
      end
      ST_ECHO: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLDOFF;
          echo_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = HOLDOFF_TC_W;
        end else begin
          cnt_d = cnt_q - ONE_W;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - ONE_W;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        echo_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops echo without waiting for a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      width_q <= '0;
      echo_q  <= 1'b0;
      done_q  <= 1'b0;
      rej_q   <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      width_q <= width_d;
      echo_q  <= echo_d;
      done_q  <= done_d;
      rej_q   <= rej_d;
      trig_q  <= trigger;
    end
  end

endmodule

// File: tb/tb_od_echo_responder.sv
// Directed bench for od_echo_responder with small timing parameters.
module tb_od_echo_responder;

  localparam int TRIG_MIN = 5;
  localparam int BURST    = 10;
  localparam int TIMEOUT  = 100;
  localparam int HOLDOFF  = 20;
  localparam int W        = 22;
  localparam int LIMIT    = 400;

  logic         clk;
  logic         reset_n;
  logic         trigger;
  logic [W-1:0] echo_width_cycles;
  logic         object_present;
  logic         echo;
  logic         busy;
  logic         done;
  logic         trig_reject;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int rej_cnt  = 0;
  int overlap  = 0;

  od_echo_responder #(
    .TRIG_MIN_CYCLES(TRIG_MIN),
    .BURST_CYCLES   (BURST),
    .TIMEOUT_CYCLES (TIMEOUT),
    .HOLDOFF_CYCLES (HOLDOFF),
    .W              (W)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .trigger          (trigger),
    .echo_width_cycles(echo_width_cycles),
    .object_present   (object_present),
    .echo             (echo),
    .busy             (busy),
    .done             (done),
    .trig_reject      (trig_reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (trig_reject) rej_cnt++;
    if (done && trig_reject) overlap++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Trigger high for n sampled edges; the next edge samples it low.
  task automatic trig_pulse(input int n);
    trigger = 1'b1;
    repeat (n) tick();
    trigger = 1'b0;
  endtask

  // mode 0: plain; 1: width change in burst + retrigger in echo/holdoff;
  // 2: trigger raised late in holdoff and left high.
  task automatic do_echo(input int n, input int exp_w, input int mode, input string tag);
    int d, w, h, done0, rej0;
    done0 = done_cnt;
    rej0  = rej_cnt;
    trig_pulse(n);
    tick();
    check({tag, "_busy_t0"}, busy, 1);
    check({tag, "_echo_t0"}, echo, 0);
    d = 0;
    while (!echo && d < LIMIT) begin
      if (mode == 1 && d == 3) echo_width_cycles = 80;
      tick();
      d++;
    end
    check({tag, "_rise_dly"}, d, BURST);
    w = 0;
    while (echo && w < LIMIT) begin
      if (mode == 1) trigger = (w >= 5 && w < 12);
      tick();
      w++;
    end
    check({tag, "_width"}, w, exp_w);
    check({tag, "_done_at_fall"}, done, 1);
    h = 0;
    while (busy && h < LIMIT) begin
      if (mode == 1) trigger = (h >= 3 && h < 10);
      if (mode == 2) trigger = (h >= 15);
      tick();
      h++;
    end
    check({tag, "_holdoff"}, h, HOLDOFF);
    check({tag, "_done_pulses"}, done_cnt - done0, 1);
    check({tag, "_rejects"}, rej_cnt - rej0, 0);
  endtask

  initial begin
    int d, rej0, done0;
    reset_n           = 1'b0;
    trigger           = 1'b0;
    echo_width_cycles = 37;
    object_present    = 1'b1;
    repeat (3) tick();
    check("rst_echo", echo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rej", trig_reject, 0);
    reset_n = 1'b1;
    tick();

    // 1: nominal
    do_echo(6, 37, 0, "s1");
    repeat (3) tick();

    // 2: short trigger rejected, then exactly minimum accepted
    rej0 = rej_cnt;
    trig_pulse(4);
    tick();
    check("s2_rej_pulse", trig_reject, 1);
    check("s2_busy", busy, 0);
    check("s2_echo", echo, 0);
    tick();
    check("s2_rej_clear", trig_reject, 0);
    check("s2_rej_count", rej_cnt - rej0, 1);
    repeat (15) tick();
    check("s2_no_echo", echo, 0);
    do_echo(5, 37, 0, "s2_min");
    repeat (3) tick();

    // 3: width substitutions
    object_present = 1'b0;
    do_echo(6, TIMEOUT, 0, "s3_noobj");
    object_present    = 1'b1;
    echo_width_cycles = 250;
    do_echo(6, TIMEOUT, 0, "s3_over");
    echo_width_cycles = 0;
    do_echo(6, 1, 0, "s3_zero");
    echo_width_cycles = 37;
    repeat (3) tick();

    // 4: width change in burst, retriggers ignored
    done0 = done_cnt;
    do_echo(6, 37, 1, "s4");
    repeat (30) tick();
    check("s4_no_extra_echo", done_cnt - done0, 1);
    check("s4_idle", busy, 0);
    echo_width_cycles = 37;

    // 5: trigger held across holdoff end
    do_echo(6, 37, 2, "s5a");
    repeat (5) tick();
    check("s5_held_ignored", busy, 0);
    trigger = 1'b0;
    repeat (2) tick();
    check("s5_still_idle", busy, 0);
    do_echo(6, 37, 0, "s5b");
    repeat (3) tick();

    // 6: async reset mid-echo
    trig_pulse(6);
    tick();
    d = 0;
    while (!echo && d < LIMIT) begin
      tick();
      d++;
    end
    check("s6_rise", d, BURST);
    repeat (10) tick();
    check("s6_echo_before_rst", echo, 1);
    #2 reset_n = 1'b0;
    #1;
    check("s6_async_echo", echo, 0);
    check("s6_async_busy", busy, 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    do_echo(6, 37, 0, "s6_after");

    check("no_done_rej_overlap", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/od_echo_responder.md
# od_echo_responder

- Cycle-accurate responder for the ultrasonic ranging interface: stands in for the sensor module.
- Accepts the trigger pulse produced by the obstacle-detection front end.
- Emulates the transducer burst delay, then drives an echo pulse whose width encodes a programmed distance.
- Used in bench and hardware-in-the-loop builds so the echo-measurement and timeout logic can be exercised without a physical sensor.

## Interface

Parameters:
- `TRIG_MIN_CYCLES`, default 500 — minimum accepted trigger high time (10 µs at 50 MHz).
- `BURST_CYCLES`, default 10000 — delay from accepted trigger fall to echo rise (200 µs).
- `TIMEOUT_CYCLES`, default 1900000 — echo width when no object is present; also the maximum echo width (38 ms).
- `HOLDOFF_CYCLES`, default 500000 — dead time after echo fall during which triggers are ignored (10 ms).
- `W`, default 22 — width of the `echo_width_cycles` port and all internal counters.

Ports:
- `clk` — input, 1 — 50 MHz system clock.
- `reset_n` — input, 1 — asynchronous, active-low reset.
- `trigger` — input, 1 — trigger from the ranging initiator, synchronous to `clk`.
- `echo_width_cycles` — input, W — programmed echo width in clk cycles.
- `object_present` — input, 1 — when 0, echo width is forced to `TIMEOUT_CYCLES`.
- `echo` — output, 1 — emulated echo pulse.
- `busy` — output, 1 — high whenever the FSM is not in IDLE.
- `done` — output, 1 — one-cycle pulse on the cycle `echo` falls.
- `trig_reject` — output, 1 — one-cycle pulse when a trigger shorter than `TRIG_MIN_CYCLES` ends.

## Operation

- Edge detection: `trig_q` registers `trigger` every cycle in all states. `rise = trigger & ~trig_q`.
- FSM states: IDLE, TRIG, BURST, ECHO, HOLDOFF.
- IDLE:
  - On `rise`, go to TRIG with `cnt = 1`.
  - A trigger that is already high when IDLE is entered is not a rise and is ignored until it falls and rises again.
- TRIG:
  - While `trigger = 1`, `cnt` increments, saturating at `TRIG_MIN_CYCLES`.
  - On the first sample with `trigger = 0`:
    - If `cnt ≥ TRIG_MIN_CYCLES`: latch the width and go to BURST.
    - Else: pulse `trig_reject` and return to IDLE.
- Width latch, evaluated in priority order at trigger fall only:
  - `object_present = 0` or `echo_width_cycles > TIMEOUT_CYCLES` → `TIMEOUT_CYCLES`.
  - `echo_width_cycles = 0` → 1.
  - Otherwise → `echo_width_cycles`.
  - Later changes to the inputs do not affect the pulse in progress.
- BURST: count `BURST_CYCLES` cycles, then go to ECHO with `echo = 1`.
- ECHO:
  - `echo` stays high for exactly the latched width in cycles.
  - On the falling edge of `echo`, `done` pulses and the FSM goes to HOLDOFF.
- HOLDOFF: count `HOLDOFF_CYCLES` cycles, then go to IDLE.
- Triggers during BURST, ECHO and HOLDOFF are ignored; no flag is raised.
- `busy = (state != IDLE)`. `busy` is combinational from the state register.
- Counters are W bits, and no counter ever exceeds `TIMEOUT_CYCLES`. Parameters must satisfy `TIMEOUT_CYCLES < 2^W` and `HOLDOFF_CYCLES < 2^W`.

## Timing

- Reset:
  - State IDLE.
  - `echo`, `done`, `trig_reject`, `busy` = 0.
  - `trig_q` and all counters = 0.
  - Asserting `reset_n` low mid-pulse drops `echo` immediately (asynchronously).
  - The first `rise` after reset release is recognised.
- Trigger high for N sampled cycles; trigger first sampled low at edge t0:
  - BURST is entered at t0.
  - `echo` rises at edge t0 + `BURST_CYCLES`.
  - `echo` falls at edge t0 + `BURST_CYCLES` + width.
  - `done` is high for the cycle following that edge.
  - IDLE is reached `HOLDOFF_CYCLES` edges after `echo` falls.
- `trig_reject` is high for the single cycle after t0 when N < `TRIG_MIN_CYCLES`.
- N = `TRIG_MIN_CYCLES` exactly is accepted.
- A trigger still high when HOLDOFF ends is not accepted until it falls and rises again.
- `done` and `trig_reject` are never asserted in the same cycle.

## Test plan

Use overrides `TRIG_MIN_CYCLES=5`, `BURST_CYCLES=10`, `TIMEOUT_CYCLES=100`, `HOLDOFF_CYCLES=20` for all scenarios.

1. Trigger high 6 cycles, `echo_width_cycles=37`, `object_present=1` → echo rises exactly 10 cycles after trigger fall, high exactly 37 cycles; `done` pulses once; `busy` low 20 cycles after echo fall.
2. Trigger high 4 cycles → `trig_reject` pulses one cycle, echo stays 0, back in IDLE. Then trigger high 5 cycles → accepted.
3. `object_present=0`, width 37 → echo high 100 cycles. `object_present=1`, width 250 → 100 cycles. Width 0 → 1 cycle.
4. Change `echo_width_cycles` from 37 to 80 during BURST, and retrigger during ECHO and HOLDOFF → echo width remains 37; no extra echo; no `trig_reject`.
5. Hold trigger high across the HOLDOFF→IDLE transition, then low, then pulse 6 cycles → only the second pulse produces an echo.
6. Assert `reset_n` low midway through an echo → `echo`/`busy` drop without waiting for a clock; after release, a 6-cycle trigger produces a normal echo.
